uart_rx_cfg: RTL and testbench

//  Configurable UART receiver; next generation of the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg_if.sv | 22 ++
 rtl/uart_rx_cfg.sv | 146 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: serial line and baud tick in, registered word and status out.
interface uart_rx_cfg_if #(
   parameter int NB_DATA = 8
);
   logic               i_rx;
   logic               i_tick;
   logic [NB_DATA-1:0] o_data;
   logic               o_valid;
   logic               o_parity_err;
   logic               o_frame_err;
   logic               o_busy;

   modport slave (
      input  i_rx, i_tick,
      output o_data, o_valid, o_parity_err, o_frame_err, o_busy
   );

   modport master (
      output i_rx, i_tick,
      input  o_data, o_valid, o_parity_err, o_frame_err, o_busy
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: generic width, optional parity, 1/2 stop bits,
// synchronised input, start-glitch rejection, registered word with error flags.
module uart_rx_cfg #(
   parameter int NB_DATA    = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int NB_STOP    = 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   uart_rx_cfg_if.slave  bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(NB_DATA);
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE/2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
   localparam logic          STOP_LAST = (NB_STOP == 2);
   localparam logic          PAR_ODD   = (PARITY_ODD != 0);
   localparam logic          PAR_EN    = (PARITY_EN != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic               rx_meta, rx_sync;
   state_t             state_q, state_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic               stop_q, stop_d;
   logic [NB_DATA-1:0] shift_q, shift_d;
   logic               perr_q, perr_d;
   logic               armed_q, armed_d;
   logic               done, ferr;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= bus.i_rx;
         rx_sync <= rx_meta;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      armed_d = armed_q;
      done    = 1'b0;
      ferr    = 1'b0;
      case (state_q)
         IDLE: begin
            // ticks are ignored here, so a tick coinciding with the edge is not counted
            if (rx_sync) armed_d = 1'b1;
            else if (armed_q) begin
               state_d = START;
               tick_d  = '0;
            end
         end
         START: if (bus.i_tick) begin
            if (tick_q == TICK_HALF) begin
               if (!rx_sync) begin
                  state_d = DATA;
                  tick_d  = '0;
                  bit_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else tick_d = tick_q + 1'b1;
         end
         DATA: if (bus.i_tick) begin
            if (tick_q == TICK_LAST) begin
               shift_d = {rx_sync, shift_q[NB_DATA-1:1]};
               tick_d  = '0;
               if (bit_q == BIT_LAST) begin
                  stop_d  = 1'b0;
                  perr_d  = 1'b0;
                  state_d = PAR_EN ? PARITY : STOP;
               end else bit_d = bit_q + 1'b1;
            end else tick_d = tick_q + 1'b1;
         end
         PARITY: if (bus.i_tick) begin
            if (tick_q == TICK_LAST) begin
               perr_d  = ((^shift_q) ^ rx_sync) != PAR_ODD;
               tick_d  = '0;
               stop_d  = 1'b0;
               state_d = STOP;
            end else tick_d = tick_q + 1'b1;
         end
         STOP: if (bus.i_tick) begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               // a low stop bit ends the frame at once and blocks restart until the line idles
               if (!rx_sync) begin
                  done    = 1'b1;
                  ferr    = 1'b1;
                  armed_d = 1'b0;
                  state_d = IDLE;
               end else if (stop_q == STOP_LAST) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else stop_d = 1'b1;
            end else tick_d = tick_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q          <= IDLE;
         tick_q           <= '0;
         bit_q            <= '0;
         stop_q           <= 1'b0;
         shift_q          <= '0;
         perr_q           <= 1'b0;
         armed_q          <= 1'b1;
         bus.o_data       <= '0;
         bus.o_valid      <= 1'b0;
         bus.o_parity_err <= 1'b0;
         bus.o_frame_err  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         stop_q      <= stop_d;
         shift_q     <= shift_d;
         perr_q      <= perr_d;
         armed_q     <= armed_d;
         bus.o_valid <= done;
         if (done) begin
            bus.o_data       <= shift_q;
            bus.o_parity_err <= PAR_EN & perr_q;
            bus.o_frame_err  <= ferr;
         end
      end
   end

   assign bus.o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, even parity and 7-bit/2-stop instances on a shared tick.
module tb_uart_rx_cfg;

   localparam int BIT = 64; // 16 ticks x 4 clocks

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic [1:0] tdiv = 2'd0;
   int n_cmp = 0;
   int n_bad = 0;
   int vc0 = 0, vc1 = 0, vc2 = 0;
   int b;
   logic [7:0] h2[$];

   uart_rx_cfg_if #(.NB_DATA(8)) if0 ();
   uart_rx_cfg_if #(.NB_DATA(8)) if1 ();
   uart_rx_cfg_if #(.NB_DATA(7)) if2 ();

   uart_rx_cfg #(.NB_DATA(8)) dut0 (.i_clk(clk), .i_reset(rst), .bus(if0));
   uart_rx_cfg #(.NB_DATA(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));
   uart_rx_cfg #(.NB_DATA(7), .NB_STOP(2)) dut2 (.i_clk(clk), .i_reset(rst), .bus(if2));

   assign if0.i_tick = tick;
   assign if1.i_tick = tick;
   assign if2.i_tick = tick;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tdiv = tdiv + 2'd1;
      tick = (tdiv == 2'd0);
   end

   always @(negedge clk) begin
      if (if0.o_valid === 1'b1) vc0++;
      if (if1.o_valid === 1'b1) vc1++;
      if (if2.o_valid === 1'b1) begin
         vc2++;
         h2.push_back({if2.o_frame_err, if2.o_data});
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int d, input logic v);
      case (d)
         0: if0.i_rx = v;
         1: if1.i_rx = v;
         default: if2.i_rx = v;
      endcase
   endtask

   // pat[0] goes on the line first; the line is left at the last bit
   task automatic send(input int d, input logic [31:0] pat, input int n);
      for (int i = 0; i < n; i++) begin
         drive(d, pat[i]);
         idle(BIT);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      if0.i_rx = 1'b1;
      if1.i_rx = 1'b1;
      if2.i_rx = 1'b1;
      idle(4);
      rst = 1'b0;
      idle(2);

      chk("rst_data",  32'(if0.o_data), 32'h0);
      chk("rst_valid", 32'(if0.o_valid), 32'h0);
      chk("rst_perr",  32'(if1.o_parity_err), 32'h0);
      chk("rst_ferr",  32'(if0.o_frame_err), 32'h0);
      chk("rst_busy",  32'(if0.o_busy), 32'h0);
      chk("rst_busy2", 32'(if2.o_busy), 32'h0);

      // 8N1 0xA5
      b = vc0;
      send(0, {1'b1, 8'hA5, 1'b0}, 10);
      idle(BIT);
      chk("a5_cnt",  32'(vc0 - b), 32'd1);
      chk("a5_data", 32'(if0.o_data), 32'hA5);
      chk("a5_perr", 32'(if0.o_parity_err), 32'h0);
      chk("a5_ferr", 32'(if0.o_frame_err), 32'h0);
      chk("a5_busy", 32'(if0.o_busy), 32'h0);

      // even parity 0x07: good parity bit, then bad
      b = vc1;
      send(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
      idle(BIT);
      chk("p_ok_cnt",  32'(vc1 - b), 32'd1);
      chk("p_ok_data", 32'(if1.o_data), 32'h07);
      chk("p_ok_perr", 32'(if1.o_parity_err), 32'h0);
      send(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
      idle(BIT);
      chk("p_bad_cnt",  32'(vc1 - b), 32'd2);
      chk("p_bad_data", 32'(if1.o_data), 32'h07);
      chk("p_bad_perr", 32'(if1.o_parity_err), 32'h1);
      chk("p_bad_ferr", 32'(if1.o_frame_err), 32'h0);

      // low stop bit then 40-bit break
      b = vc0;
      send(0, {1'b0, 8'h3C, 1'b0}, 10);
      idle(40 * BIT);
      chk("brk_cnt",  32'(vc0 - b), 32'd1);
      chk("brk_data", 32'(if0.o_data), 32'h3C);
      chk("brk_ferr", 32'(if0.o_frame_err), 32'h1);
      chk("brk_busy", 32'(if0.o_busy), 32'h0);
      drive(0, 1'b1);
      idle(BIT);
      send(0, {1'b1, 8'h81, 1'b0}, 10);
      idle(BIT);
      chk("rearm_cnt",  32'(vc0 - b), 32'd2);
      chk("rearm_data", 32'(if0.o_data), 32'h81);
      chk("rearm_ferr", 32'(if0.o_frame_err), 32'h0);

      // 6-tick glitch
      b = vc0;
      drive(0, 1'b0);
      idle(12);
      chk("gl_busy_mid", 32'(if0.o_busy), 32'h1);
      idle(12);
      drive(0, 1'b1);
      idle(BIT);
      chk("gl_cnt",  32'(vc0 - b), 32'd0);
      chk("gl_data", 32'(if0.o_data), 32'h81);
      chk("gl_busy", 32'(if0.o_busy), 32'h0);

      // 7 data bits, 2 stop bits, back to back
      b = vc2;
      h2.delete();
      send(2, {2'b11, 7'h55, 1'b0}, 10);
      send(2, {2'b11, 7'h2A, 1'b0}, 10);
      idle(BIT);
      chk("b2b_cnt", 32'(vc2 - b), 32'd2);
      chk("b2b_f0",  32'((h2.size() > 0) ? h2[0] : 8'hFF), 32'h55);
      chk("b2b_f1",  32'((h2.size() > 1) ? h2[1] : 8'hFF), 32'h2A);
      send(2, {1'b0, 1'b1, 7'h33, 1'b0}, 10);
      drive(2, 1'b1);
      idle(BIT);
      chk("stop2_cnt",  32'(vc2 - b), 32'd3);
      chk("stop2_data", 32'(if2.o_data), 32'h33);
      chk("stop2_ferr", 32'(if2.o_frame_err), 32'h1);
      chk("stop2_busy", 32'(if2.o_busy), 32'h0);

      // reset in the middle of data bit 3 of 0xC3
      b = vc0;
      send(0, 32'b0110, 4);
      drive(0, 1'b0);
      idle(32);
      rst = 1'b1;
      drive(0, 1'b1);
      idle(2);
      chk("mrst_valid", 32'(if0.o_valid), 32'h0);
      chk("mrst_data",  32'(if0.o_data), 32'h0);
      chk("mrst_ferr",  32'(if0.o_frame_err), 32'h0);
      chk("mrst_busy",  32'(if0.o_busy), 32'h0);
      rst = 1'b0;
      idle(2 * BIT);
      chk("mrst_cnt", 32'(vc0 - b), 32'd0);
      send(0, {1'b1, 8'hC3, 1'b0}, 10);
      idle(BIT);
      chk("c3_cnt",  32'(vc0 - b), 32'd1);
      chk("c3_data", 32'(if0.o_data), 32'hC3);
      chk("c3_ferr", 32'(if0.o_frame_err), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
